mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single RAM port (mem_operation/mem_opdone protocol: 01 read, 11 write, 00 none) between NUM_REQ bus masters, e.g. the CPU load/store unit and the matrix accelerators.
- Round-robin arbitration; a grant is held for as long as the owner keeps a non-00 operation asserted, so multi-address bursts run uninterrupted.
- Sits between the requesters and the RAM controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_op_i  in  2*NUM_REQ  per-requester operation; slice r is [2r+1:2r].
- req_addr_i  in  ADDR_W*NUM_REQ  per-requester address.
- req_wdata_i  in  DATA_W*NUM_REQ  per-requester write data.
- req_opdone_o  out  NUM_REQ  per-requester completion pulse.
- req_rdata_o  out  DATA_W  read data, broadcast to all requesters.
- mem_op_o  out  2  operation to RAM.
- mem_addr_o  out  ADDR_W  address to RAM.
- mem_wdata_o  out  DATA_W  write data to RAM.
- mem_opdone_i  in  1  RAM completion pulse.
- mem_rdata_i  in  DATA_W  RAM read data.
- grant_o  out  NUM_REQ  one-hot owner; all zero when idle.
- busy_o  out  1  high while a grant is held.
- timeout_o  out  1  one-cycle watchdog pulse (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - grant_o=0, busy_o=0, timeout_o=0.
  - Round-robin pointer=0, state=IDLE.
  - mem_op_o=00, mem_addr_o=0, mem_wdata_o=0, req_opdone_o=0.
  - Reset asserted mid-burst aborts the grant in the same edge; no opdone is forwarded afterwards.
- Request: requester r requests when req_op_i[r] is 01 or 11. Code 10 is treated as 00 and is never forwarded.
- IDLE state:
  - If any request is present, pick the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - Register grant_o to that one-hot value, set busy_o=1, go to BUSY.
  - Latency: request sampled at edge N gives grant_o valid after edge N; the RAM sees the operation from then on.
- BUSY state:
  - mem_op_o, mem_addr_o and mem_wdata_o are a combinational mux of the owner's inputs.
  - mem_opdone_i is routed combinationally to the owner's req_opdone_o bit only; all other bits stay 0.
  - req_rdata_o = mem_rdata_i at all times.
  - The owner may change address while holding its operation (burst); each opdone belongs to the address current at that time.
  - When the owner's op reads 00 at an edge: go to IDLE, clear grant_o and busy_o, set pointer = owner+1 (wrapping).
- Turnaround: exactly one idle cycle between grants, with mem_op_o=00. No back-to-back handover.
- Outside BUSY: mem outputs are driven to 0 and op to 00. A stray mem_opdone_i is dropped.
- Simultaneous requests: resolved strictly by pointer order. Starvation bound is (NUM_REQ-1) bursts.
- A requester that drops its request before being granted is skipped without penalty.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in BUSY; it resets on grant and on every mem_opdone_i.
  - When the counter reaches TIMEOUT_CYCLES-1, force a return to IDLE and pulse timeout_o for one cycle.
  - The pointer advances past the offender. The offender's outstanding request is re-arbitrated normally.
- When undefined: no counter is built, timeout_o is tied 0, and a grant is held indefinitely.

Decomposition:
- Shared package knight_mem_pkg holds:
  - MEM_OP_NONE=2'b00, MEM_OP_READ=2'b01, MEM_OP_WRITE=2'b11.
  - The arbiter state enum (ARB_IDLE, ARB_BUSY).
  - A helper function is_mem_req(op).
- One sub-module, rr_picker: combinational round-robin priority picker.
  - Inputs: req vector, pointer. Outputs: one-hot grant, valid.

Test Plan:
- Single read: req0 op=01, addr=0x10; RAM returns 0xABCD with opdone 3 cycles later. Expect grant_o=01 one cycle after the request, mem_addr_o=0x10, req_opdone_o[0] pulse, req_rdata_o=0xABCD.
- Contention, pointer=0: req0 and req1 both issue writes in the same cycle. Expect req0 served first; after req0 drops to 00, one idle cycle with mem_op_o=00, then grant_o=10.
- Burst hold: req0 holds op=01 over addresses 1..4 (4 opdones) while req1 requests. Expect grant_o to stay 01 for all four opdones; req1 is granted only after req0 returns to 00.
- Fairness: both requesters issue continuous repeated single-access bursts. Expect grants to alternate 01,10,01,10, and req_opdone_o never pulses on a non-owner.
- Reset mid-burst: assert reset while grant_o=10. Expect grant_o=0 and mem_op_o=00 on the next edge, an opdone arriving afterwards dropped, and the pointer reset so req0 wins the next contention.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: req0 is granted and the RAM never responds. Expect timeout_o pulse 8 cycles after the grant, return to IDLE, then req1 granted.

Source files
------------

// File: rtl/knight_mem_pkg.sv
// Shared definitions for the RAM port arbiter: operation codes,
// arbiter state encoding and a request decode helper.
package knight_mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Only read and write count as requests; the unused code 2'b10 is ignored.
  function automatic logic is_mem_req(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
// master: the arbiter's view; slave: the surrounding requesters and RAM.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [2*NUM_REQ-1:0]      req_op_i;
  logic [ADDR_W*NUM_REQ-1:0] req_addr_i;
  logic [DATA_W*NUM_REQ-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        req_opdone_o;
  logic [DATA_W-1:0]         req_rdata_o;
  logic [1:0]                mem_op_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic                      mem_opdone_i;
  logic [DATA_W-1:0]         mem_rdata_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      busy_o;
  logic                      timeout_o;

  modport master (
    input  req_op_i, req_addr_i, req_wdata_i, mem_opdone_i, mem_rdata_i,
    output req_opdone_o, req_rdata_o, mem_op_o, mem_addr_o, mem_wdata_o,
           grant_o, busy_o, timeout_o
  );

  modport slave (
    output req_op_i, req_addr_i, req_wdata_i, mem_opdone_i, mem_rdata_i,
    input  req_opdone_o, req_rdata_o, mem_op_o, mem_addr_o, mem_wdata_o,
           grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after
// ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // Scan from the pointer upward and keep only the first hit.
  always_comb begin : pick
    int idx;
    // NOTE: every output of a combinational block gets a default up front,
    // so no path leaves it unassigned and no latch is inferred.
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NUM_REQ masters.
// A grant is held while the owner keeps a read/write operation asserted,
// followed by one idle turnaround cycle.
// Optional watchdog: define ARB_TIMEOUT_EN to build the TIMEOUT_CYCLES
// counter that forcibly releases a grant whose RAM never responds.
module mem_port_arbiter
  import knight_mem_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_valid;
  logic [1:0]         owner_op;
  logic [ADDR_W-1:0]  owner_addr;
  logic [DATA_W-1:0]  owner_wdata;
  logic               owner_req;
  logic               in_busy;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] opdone;

  // Decode each requester's op into a single request bit.
  always_comb begin
    req_vec = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_vec[r] = is_mem_req(bus.req_op_i[2*r +: 2]);
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req   (req_vec),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Convert the picker's one-hot grant into an owner index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_idx = PTR_W'(i);
    end
  end

  assign in_busy     = (state == ARB_BUSY);
  assign owner_op    = bus.req_op_i[2*int'(owner) +: 2];
  assign owner_addr  = bus.req_addr_i[ADDR_W*int'(owner) +: ADDR_W];
  assign owner_wdata = bus.req_wdata_i[DATA_W*int'(owner) +: DATA_W];
  assign owner_req   = is_mem_req(owner_op);
  assign next_ptr    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

  // Route the RAM completion to the owner only; stray completions are dropped.
  always_comb begin
    opdone = '0;
    if (in_busy) opdone[owner] = bus.mem_opdone_i;
  end

  assign bus.mem_op_o     = (in_busy && owner_req) ? owner_op : MEM_OP_NONE;
  assign bus.mem_addr_o   = in_busy ? owner_addr  : '0;
  assign bus.mem_wdata_o  = in_busy ? owner_wdata : '0;
  assign bus.req_opdone_o = opdone;
  assign bus.req_rdata_o  = bus.mem_rdata_i;
  assign bus.grant_o      = grant;
  assign bus.busy_o       = busy;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout;

  assign timeout_hit = in_busy && owner_req && !bus.mem_opdone_i &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts busy cycles since the grant or the last completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (!in_busy || bus.mem_opdone_i || timeout_hit) wd_cnt <= '0;
      else                                             wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign bus.timeout_o = timeout;
`else
  assign timeout_hit   = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, hold in BUSY until the owner lets go.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state <= ARB_BUSY;
            grant <= pick_grant;
            busy  <= 1'b1;
            owner <= pick_idx;
          end
        end
        ARB_BUSY: begin
          if (!owner_req || timeout_hit) begin
            state <= ARB_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
